// File: rtl/microstepper_pkg.sv
// Shared types and constants for the parametrised microstepper control.
// Holds the chopper state encoding and the phase-offset helper.
package microstepper_pkg;

   localparam int PCW = 8;
   localparam int TW  = 10;
   localparam int BW  = 8;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      ON,
      OFF
   } chop_state_t;

   function automatic int phase_offset(
      input int k,
      input int n,
      input int steps
   );
      return (k * steps) / n;
   endfunction

endpackage

// File: rtl/microstepper_chopper_channel.sv
// One chopper channel: blank / on / off FSM with its timers,
// decay-mode decode and the two-leg bridge mapping.
module microstepper_chopper_channel #(
   parameter int TW = microstepper_pkg::TW,
   parameter int BW = microstepper_pkg::BW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          enable_i,
   input  logic          cmp_i,
   input  logic          fault_en_i,
   input  logic [BW-1:0] blank_time_i,
   input  logic [BW-1:0] min_on_i,
   input  logic [TW-1:0] off_time_i,
   input  logic [TW-1:0] fd_thr_i,
   input  logic [1:0]    s_i,
   output logic [1:0]    h_o,
   output logic [1:0]    l_o,
   output logic          chop_off_o,
   output logic          trip_o
);
   import microstepper_pkg::*;

   chop_state_t   state_q, state_d;
   logic [BW-1:0] blank_q, blank_d;
   logic [BW-1:0] minon_q, minon_d;
   logic [TW-1:0] off_q, off_d;

   logic [BW-1:0] blank_ld;
   logic [TW-1:0] off_ld;
   logic [BW-1:0] minon_dec;
   logic          in_off;
   logic          fast;

   // Zero-length timers still dwell one cycle.
   assign blank_ld  = (blank_time_i == '0) ? BW'(1) : blank_time_i;
   assign off_ld    = (off_time_i == '0) ? TW'(1) : off_time_i;
   assign minon_dec = (minon_q == '0) ? '0 : minon_q - 1'b1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         blank_q <= '0;
         minon_q <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         blank_q <= blank_d;
         minon_q <= minon_d;
         off_q   <= off_d;
      end
   end

   always_comb begin
      state_d = state_q;
      blank_d = blank_q;
      minon_d = minon_q;
      off_d   = off_q;
      if (!enable_i) begin
         state_d = IDLE;
         blank_d = '0;
         minon_d = '0;
         off_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = BLANK;
               blank_d = blank_ld;
               minon_d = min_on_i;
            end
            BLANK: begin
               blank_d = blank_q - 1'b1;
               minon_d = minon_dec;
               if (blank_q <= BW'(1)) state_d = ON;
            end
            ON: begin
               minon_d = minon_dec;
               if (cmp_i) begin
                  state_d = OFF;
                  off_d   = off_ld;
               end
            end
            OFF: begin
               off_d = off_q - 1'b1;
               if (off_q <= TW'(1)) begin
                  state_d = BLANK;
                  blank_d = blank_ld;
                  minon_d = min_on_i;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign in_off = (state_q == OFF);
   assign fast   = (off_q >= fd_thr_i);

   always_comb begin
      chop_off_o = in_off;
      trip_o = enable_i & (state_q == ON) & cmp_i
             & fault_en_i & (minon_q != '0);
      unique case (1'b1)
         (in_off & fast): begin
            h_o = ~s_i;
            l_o = s_i;
         end
         (in_off & ~fast): begin
            h_o = 2'b00;
            l_o = 2'b11;
         end
         default: begin
            h_o = s_i;
            l_o = ~s_i;
         end
      endcase
   end

endmodule

// File: rtl/microstepper_control_n.sv
// N-phase microstepper control: input sync, phase counters,
// per-channel choppers, latched over-current fault and gate gating.
module microstepper_control_n #(
   parameter int NUM_PHASES      = 3,
   parameter int PCW             = microstepper_pkg::PCW,
   parameter int STEPS_PER_CYCLE = 192,
   parameter int TW              = microstepper_pkg::TW,
   parameter int BW              = microstepper_pkg::BW
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      step,
   input  logic                      dir,
   input  logic                      enable_in,
   input  logic [NUM_PHASES-1:0]     analog_cmp,
   input  logic [2*NUM_PHASES-1:0]   s,
   input  logic [BW-1:0]             config_blank_time,
   input  logic [BW-1:0]             config_min_on_time,
   input  logic [TW-1:0]             config_off_time,
   input  logic [TW-1:0]             config_fastdecay_threshold,
   input  logic                      config_fault_enable,
   input  logic                      config_invert_highside,
   input  logic                      config_invert_lowside,
   output logic [2*NUM_PHASES-1:0]   phase_h_out,
   output logic [2*NUM_PHASES-1:0]   phase_l_out,
   output logic [NUM_PHASES*PCW-1:0] phase_ct,
   output logic                      faultn,
   output logic [NUM_PHASES-1:0]     fault_channel,
   output logic [NUM_PHASES-1:0]     chop_off
);
   import microstepper_pkg::*;

   logic [2:0] step_s_q;
   logic [1:0] dir_s_q;
   logic [1:0] en_s_q;
   logic       step_rise;
   logic       dir_s;
   logic       en;

   logic [NUM_PHASES-1:0] fault_q, fault_d;
   logic [NUM_PHASES-1:0] trip;
   logic                  faultn_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         step_s_q <= '0;
         dir_s_q  <= '0;
         en_s_q   <= '0;
      end else begin
         step_s_q <= {step_s_q[1:0], step};
         dir_s_q  <= {dir_s_q[0], dir};
         en_s_q   <= {en_s_q[0], enable_in};
      end
   end

   assign step_rise = step_s_q[1] & ~step_s_q[2];
   assign dir_s     = dir_s_q[1];
   assign en        = en_s_q[1];

   // Fault cause is sticky; faultn follows one cycle behind it.
   assign fault_d = fault_q | trip;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fault_q  <= '0;
         faultn_q <= 1'b1;
      end else begin
         fault_q  <= fault_d;
         faultn_q <= ~|fault_q;
      end
   end

   assign faultn        = faultn_q;
   assign fault_channel = fault_q;

   for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ch
      localparam logic [PCW-1:0] RST_CT =
         PCW'(phase_offset(k, NUM_PHASES, STEPS_PER_CYCLE));
      localparam logic [PCW-1:0] TOP_CT = PCW'(STEPS_PER_CYCLE - 1);

      logic [PCW-1:0] ct_q, ct_d;
      logic [1:0]     h, l;

      always_comb begin
         ct_d = ct_q;
         if (step_rise) begin
            if (dir_s) ct_d = (ct_q == TOP_CT) ? '0 : ct_q + 1'b1;
            else       ct_d = (ct_q == '0) ? TOP_CT : ct_q - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!resetn) ct_q <= RST_CT;
         else         ct_q <= ct_d;
      end

      assign phase_ct[k*PCW +: PCW] = ct_q;

      microstepper_chopper_channel #(
         .TW (TW),
         .BW (BW)
      ) u_chop (
         .clk          (clk),
         .resetn       (resetn),
         .enable_i     (en),
         .cmp_i        (analog_cmp[k]),
         .fault_en_i   (config_fault_enable),
         .blank_time_i (config_blank_time),
         .min_on_i     (config_min_on_time),
         .off_time_i   (config_off_time),
         .fd_thr_i     (config_fastdecay_threshold),
         .s_i          (s[2*k +: 2]),
         .h_o          (h),
         .l_o          (l),
         .chop_off_o   (chop_off[k]),
         .trip_o       (trip[k])
      );

      assign phase_h_out[2*k +: 2] =
         (h & {2{faultn_q & en}}) ^ {2{config_invert_highside}};
      assign phase_l_out[2*k +: 2] =
         (l | {2{~en}}) ^ {2{config_invert_lowside}};
   end

endmodule

// File: tb/tb_microstepper_control_n.sv
// Directed bench for microstepper_control_n with a short random
// shoot-through sweep under both inversion settings.
module tb_microstepper_control_n;

   localparam int NP  = 3;
   localparam int PCW = 8;
   localparam int TW  = 10;
   localparam int BW  = 8;

   logic clk = 1'b0;
   logic resetn, step, dir, enable_in;
   logic [NP-1:0]   analog_cmp;
   logic [2*NP-1:0] s;
   logic [BW-1:0]   cfg_blank, cfg_minon;
   logic [TW-1:0]   cfg_off, cfg_thr;
   logic            cfg_fe, inv_h, inv_l;
   logic [2*NP-1:0] h_out, l_out;
   logic [NP*PCW-1:0] phase_ct;
   logic            faultn;
   logic [NP-1:0]   fault_channel, chop_off;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   microstepper_control_n #(
      .NUM_PHASES      (NP),
      .PCW             (PCW),
      .STEPS_PER_CYCLE (192),
      .TW              (TW),
      .BW              (BW)
   ) dut (
      .clk                        (clk),
      .resetn                     (resetn),
      .step                       (step),
      .dir                        (dir),
      .enable_in                  (enable_in),
      .analog_cmp                 (analog_cmp),
      .s                          (s),
      .config_blank_time          (cfg_blank),
      .config_min_on_time         (cfg_minon),
      .config_off_time            (cfg_off),
      .config_fastdecay_threshold (cfg_thr),
      .config_fault_enable        (cfg_fe),
      .config_invert_highside     (inv_h),
      .config_invert_lowside      (inv_l),
      .phase_h_out                (h_out),
      .phase_l_out                (l_out),
      .phase_ct                   (phase_ct),
      .faultn                     (faultn),
      .fault_channel              (fault_channel),
      .chop_off                   (chop_off)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_step();
      step = 1'b1;
      cyc(3);
      step = 1'b0;
      cyc(3);
   endtask

   function automatic logic [PCW-1:0] ct(input int k);
      return phase_ct[k*PCW +: PCW];
   endfunction

   // Reset, enable, and trip channel 0 on cycle 8 after BLANK entry.
   task automatic trip_run(input logic fe, input logic [BW-1:0] mo);
      resetn = 1'b0;
      enable_in = 1'b0;
      analog_cmp = '0;
      cyc(3);
      resetn = 1'b1;
      cfg_fe = fe;
      cfg_minon = mo;
      cyc(2);
      enable_in = 1'b1;
      cyc(3);
      cyc(7);
      analog_cmp = 3'b001;
      cyc(1);
      analog_cmp = '0;
   endtask

   initial begin
      #1ms;
      bad++;
      $display("FAIL timeout: got=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      resetn = 1'b0;
      step = 1'b0;
      dir = 1'b1;
      enable_in = 1'b0;
      analog_cmp = '0;
      s = 6'b000001;
      cfg_blank = 8'd4;
      cfg_minon = 8'd0;
      cfg_off = 10'd10;
      cfg_thr = 10'd6;
      cfg_fe = 1'b0;
      inv_h = 1'b0;
      inv_l = 1'b0;
      cyc(4);

      chk("rst_ct", 32'(phase_ct), 32'h804000);
      chk("rst_faultn", 32'(faultn), 1);
      chk("rst_fch", 32'(fault_channel), 0);
      chk("rst_off", 32'(chop_off), 0);
      chk("rst_h", 32'(h_out), 0);
      chk("rst_l", 32'(l_out), 6'b111111);

      resetn = 1'b1;
      cyc(2);

      repeat (191) pulse_step();
      chk("ct0_191", 32'(ct(0)), 191);
      pulse_step();
      chk("ct0_wrap", 32'(ct(0)), 0);
      chk("ct1_full", 32'(ct(1)), 64);
      chk("ct2_full", 32'(ct(2)), 128);
      dir = 1'b0;
      cyc(4);
      pulse_step();
      chk("ct0_dn", 32'(ct(0)), 191);
      chk("ct1_dn", 32'(ct(1)), 63);
      chk("ct2_dn", 32'(ct(2)), 127);

      enable_in = 1'b1;
      cyc(12);
      chk("on_off", 32'(chop_off), 0);
      chk("on_h", 32'(h_out[1:0]), 2'b01);
      chk("on_l", 32'(l_out[1:0]), 2'b10);
      analog_cmp = 3'b001;
      cyc(1);
      analog_cmp = '0;
      for (int j = 1; j <= 10; j++) begin
         chk($sformatf("off_%0d", j), 32'(chop_off), 3'b001);
         if (j <= 5) begin
            chk($sformatf("fast_h%0d", j), 32'(h_out[1:0]), 2'b10);
            chk($sformatf("fast_l%0d", j), 32'(l_out[1:0]), 2'b01);
         end else begin
            chk($sformatf("slow_h%0d", j), 32'(h_out[1:0]), 2'b00);
            chk($sformatf("slow_l%0d", j), 32'(l_out[1:0]), 2'b11);
         end
         if (j == 10) analog_cmp = 3'b001;
         cyc(1);
      end
      for (int m = 1; m <= 5; m++) begin
         chk($sformatf("blank_%0d", m), 32'(chop_off), 0);
         chk($sformatf("blank_h%0d", m), 32'(h_out[1:0]), 2'b01);
         cyc(1);
      end
      chk("retrip", 32'(chop_off), 3'b001);
      analog_cmp = '0;
      cyc(12);

      trip_run(1'b1, 8'd20);
      chk("flt_ch", 32'(fault_channel), 3'b001);
      chk("flt_n_lag", 32'(faultn), 1);
      chk("flt_off", 32'(chop_off), 3'b001);
      cyc(1);
      chk("flt_n", 32'(faultn), 0);
      chk("flt_h", 32'(h_out), 0);
      chk("flt_l", 32'(l_out), 6'b111101);
      enable_in = 1'b0;
      cyc(5);
      enable_in = 1'b1;
      cyc(5);
      chk("flt_sticky", 32'(fault_channel), 3'b001);
      chk("flt_n_sticky", 32'(faultn), 0);

      trip_run(1'b1, 8'd3);
      cyc(1);
      chk("minon_sat", 32'(fault_channel), 0);
      chk("minon_sat_n", 32'(faultn), 1);

      trip_run(1'b0, 8'd20);
      chk("nofe_off", 32'(chop_off), 3'b001);
      cyc(1);
      chk("nofe_ch", 32'(fault_channel), 0);
      chk("nofe_n", 32'(faultn), 1);

      cyc(1);
      enable_in = 1'b0;
      cyc(2);
      chk("dis_h", 32'(h_out), 0);
      chk("dis_l", 32'(l_out), 6'b111111);
      chk("dis_still", 32'(chop_off), 3'b001);
      cyc(1);
      chk("dis_idle", 32'(chop_off), 0);

      analog_cmp = 3'b001;
      enable_in = 1'b1;
      cyc(7);
      chk("reen_blank", 32'(chop_off), 0);
      cyc(1);
      chk("reen_trip", 32'(chop_off), 3'b001);
      analog_cmp = '0;
      cyc(15);
      chk("pre_fall_on", 32'(chop_off), 0);

      cfg_fe = 1'b1;
      enable_in = 1'b0;
      cyc(2);
      analog_cmp = 3'b001;
      cyc(1);
      analog_cmp = '0;
      chk("fall_fch", 32'(fault_channel), 0);
      chk("fall_off", 32'(chop_off), 0);
      cyc(1);
      chk("fall_n", 32'(faultn), 1);

      inv_h = 1'b1;
      inv_l = 1'b1;
      #1;
      chk("inv_h", 32'(h_out), 6'b111111);
      chk("inv_l", 32'(l_out), 0);

      enable_in = 1'b1;
      cfg_fe = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         cyc(1);
         chk("shoot", 32'((h_out ^ {6{inv_h}}) & (l_out ^ {6{inv_l}})), 0);
         s = 6'($urandom);
         analog_cmp = 3'($urandom);
         step = 1'($urandom);
         dir = 1'($urandom_range(0, 7) == 0) ? ~dir : dir;
         if ($urandom_range(0, 63) == 0) enable_in = ~enable_in;
         if ($urandom_range(0, 31) == 0) begin
            cfg_blank = 8'($urandom_range(0, 6));
            cfg_minon = 8'($urandom_range(0, 12));
            cfg_off = 10'($urandom_range(0, 15));
            cfg_thr = 10'($urandom_range(0, 17));
            cfg_fe = 1'($urandom);
         end
         inv_h = (i >= 1500);
         inv_l = (i >= 750 && i < 2250);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
